// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers pixel coordinates and colour from a VGA-style
// timing stream and judges whether that stream matches the configured
// geometry.
//
// Inputs are registered once (stage 1). Sync and de edges are detected on
// the stage-1 copies. All outputs are registered (stage 2), so an input
// sampled at edge k is visible on the outputs after edge k+1.
//
// Ports
//   clk_pix             pixel clock (single domain)
//   rst_pix             synchronous active-high reset
//   hsync, vsync, de    timing inputs; syncs active low when SYNC_NEG=1
//   r, g, b             pixel colour, meaningful while de is high
//   rx_x, rx_y          coordinate of the pixel currently on rx_rgb
//   rx_rgb              {r,g,b} of that pixel, 3'b000 when not valid
//   rx_valid            an active pixel is presented this cycle
//   rx_frame            frame counter, advances on each vsync assertion
//   locked              timing has matched for LOCK_FRAMES clean frames
//   err_h, err_v        one-cycle line / frame timing error pulses
module vga_timing_rx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int SYNC_NEG    = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       de,
  input  logic       r,
  input  logic       g,
  input  logic       b,
  output logic [9:0] rx_x,
  output logic [9:0] rx_y,
  output logic [2:0] rx_rgb,
  output logic       rx_valid,
  output logic [9:0] rx_frame,
  output logic       locked,
  output logic       err_h,
  output logic       err_v
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Level a sync line rests at when not asserted.
  localparam logic        SYNC_IDLE  = (SYNC_NEG != 0) ? 1'b1 : 1'b0;
  localparam logic [10:0] H_ACTIVE_C = 11'(H_ACTIVE);
  localparam logic [9:0]  H_TOTAL_C  = 10'(H_TOTAL);
  localparam logic [9:0]  V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [7:0]  LOCK_C     = 8'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX    = 10'h3ff;

  // Stage-1 input copies and their one-cycle-old versions for edge detect.
  logic       hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, de_s1_q, de_s1_d;
  logic [2:0] rgb_s1_q, rgb_s1_d;
  logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;

  // Counters and tracking state.
  logic [9:0] px_q, px_d, ln_q, ln_d, hp_q, hp_d;
  logic       h_seen_q, h_seen_d, v_seen_q, v_seen_d, dirty_q, dirty_d;
  logic [7:0] clean_q, clean_d;
  state_e     state_q, state_d;

  // Output registers.
  logic [9:0] rx_x_q, rx_x_d, rx_y_q, rx_y_d, rx_frame_q, rx_frame_d;
  logic [2:0] rx_rgb_q, rx_rgb_d;
  logic       rx_valid_q, rx_valid_d, locked_q, locked_d;
  logic       err_h_q, err_h_d, err_v_q, err_v_d;

  // Combinational event decode.
  logic        hs_edge_s, vs_edge_s, de_rise_s, de_fall_s;
  logic [10:0] px_len_s;
  logic [9:0]  ln_cur_s;
  logic        err_any_s, unlock_s;

  // Next-state logic for every register in the block.
  always_comb begin
    hs_s1_d    = hsync;
    vs_s1_d    = vsync;
    de_s1_d    = de;
    rgb_s1_d   = {r, g, b};
    hs_prev_d  = hs_s1_q;
    vs_prev_d  = vs_s1_q;
    de_prev_d  = de_s1_q;

    // A sync is "active" when it differs from its idle level.
    hs_edge_s  = ((hs_s1_q ^ SYNC_IDLE) == 1'b1) && ((hs_prev_q ^ SYNC_IDLE) == 1'b0);
    vs_edge_s  = ((vs_s1_q ^ SYNC_IDLE) == 1'b1) && ((vs_prev_q ^ SYNC_IDLE) == 1'b0);
    de_rise_s  = de_s1_q && !de_prev_q;
    de_fall_s  = !de_s1_q && de_prev_q;

    // Pixel counter: restart at de rise, saturate during overlong lines.
    if (de_rise_s) begin
      px_d = 10'd0;
    end else if (de_s1_q && (px_q != CNT_MAX)) begin
      px_d = px_q + 10'd1;
    end else begin
      px_d = px_q;
    end
    // Widened so a saturated count still mismatches any legal width.
    px_len_s = {1'b0, px_q} + 11'd1;

    // Line count including a de fall in this same cycle, so a coincident
    // vsync checks the completed line total before clearing.
    if (de_fall_s && (ln_q != CNT_MAX)) begin
      ln_cur_s = ln_q + 10'd1;
    end else begin
      ln_cur_s = ln_q;
    end
    ln_d = vs_edge_s ? 10'd0 : ln_cur_s;

    // hsync period: 1 at assertion, so it reads H_TOTAL at the next one.
    if (hs_edge_s) begin
      hp_d = 10'd1;
    end else if (hp_q != CNT_MAX) begin
      hp_d = hp_q + 10'd1;
    end else begin
      hp_d = hp_q;
    end

    err_h_d = (de_fall_s && (px_len_s != H_ACTIVE_C)) ||
              (hs_edge_s && h_seen_q && (hp_q != H_TOTAL_C));
    err_v_d = vs_edge_s && v_seen_q && (ln_cur_s != V_ACTIVE_C);
    err_any_s = err_h_d || err_v_d;

    // Lock state machine.
    state_d = state_q;
    clean_d = clean_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_edge_s) begin
          state_d = ST_ACQUIRE;
          clean_d = 8'd0;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_ACQUIRE: begin
        if (vs_edge_s) begin
          if (err_any_s || dirty_q) begin
            clean_d = 8'd0;
          end else if ((clean_q + 8'd1) >= LOCK_C) begin
            clean_d = clean_q + 8'd1;
            state_d = ST_LOCKED;
          end else begin
            clean_d = clean_q + 8'd1;
          end
        end else if (err_any_s) begin
          clean_d = 8'd0;
        end else begin
          clean_d = clean_q;
        end
      end
      ST_LOCKED: begin
        if (err_any_s) begin
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        clean_d = 8'd0;
      end
    endcase
    unlock_s = (state_q == ST_LOCKED) && err_any_s;

    // Errors seen since the last vsync disqualify the frame in progress.
    if (vs_edge_s) begin
      dirty_d = 1'b0;
    end else if (err_any_s) begin
      dirty_d = 1'b1;
    end else begin
      dirty_d = dirty_q;
    end

    // The first hsync after losing lock has no valid reference period.
    if (unlock_s) begin
      h_seen_d = 1'b0;
    end else if (hs_edge_s) begin
      h_seen_d = 1'b1;
    end else begin
      h_seen_d = h_seen_q;
    end
    v_seen_d = vs_edge_s ? 1'b1 : v_seen_q;

    rx_x_d     = px_d;
    rx_y_d     = ln_cur_s;
    rx_valid_d = de_s1_q;
    rx_rgb_d   = de_s1_q ? rgb_s1_q : 3'b000;
    rx_frame_d = vs_edge_s ? (rx_frame_q + 10'd1) : rx_frame_q;
    locked_d   = (state_d == ST_LOCKED);
  end

  // All registers; reset returns stage 1 to idle sync levels and clears the rest.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      hs_s1_q    <= SYNC_IDLE;
      vs_s1_q    <= SYNC_IDLE;
      de_s1_q    <= 1'b0;
      rgb_s1_q   <= 3'b000;
      hs_prev_q  <= SYNC_IDLE;
      vs_prev_q  <= SYNC_IDLE;
      de_prev_q  <= 1'b0;
      px_q       <= 10'd0;
      ln_q       <= 10'd0;
      hp_q       <= 10'd0;
      h_seen_q   <= 1'b0;
      v_seen_q   <= 1'b0;
      dirty_q    <= 1'b0;
      clean_q    <= 8'd0;
      state_q    <= ST_SEARCH;
      rx_x_q     <= 10'd0;
      rx_y_q     <= 10'd0;
      rx_rgb_q   <= 3'b000;
      rx_valid_q <= 1'b0;
      rx_frame_q <= 10'd0;
      locked_q   <= 1'b0;
      err_h_q    <= 1'b0;
      err_v_q    <= 1'b0;
    end else begin
      hs_s1_q    <= hs_s1_d;
      vs_s1_q    <= vs_s1_d;
      de_s1_q    <= de_s1_d;
      rgb_s1_q   <= rgb_s1_d;
      hs_prev_q  <= hs_prev_d;
      vs_prev_q  <= vs_prev_d;
      de_prev_q  <= de_prev_d;
      px_q       <= px_d;
      ln_q       <= ln_d;
      hp_q       <= hp_d;
      h_seen_q   <= h_seen_d;
      v_seen_q   <= v_seen_d;
      dirty_q    <= dirty_d;
      clean_q    <= clean_d;
      state_q    <= state_d;
      rx_x_q     <= rx_x_d;
      rx_y_q     <= rx_y_d;
      rx_rgb_q   <= rx_rgb_d;
      rx_valid_q <= rx_valid_d;
      rx_frame_q <= rx_frame_d;
      locked_q   <= locked_d;
      err_h_q    <= err_h_d;
      err_v_q    <= err_v_d;
    end
  end

  assign rx_x     = rx_x_q;
  assign rx_y     = rx_y_q;
  assign rx_rgb   = rx_rgb_q;
  assign rx_valid = rx_valid_q;
  assign rx_frame = rx_frame_q;
  assign locked   = locked_q;
  assign err_h    = err_h_q;
  assign err_v    = err_v_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx using a reduced 6x4 active / 9x5 total geometry
// so that a thousand-frame wrap fits in a short run. A frame-level model
// predicts outputs from the driven stream; literal checks pin key moments.
module tb_vga_timing_rx;

  localparam int HA = 6;
  localparam int HT = 9;
  localparam int VA = 4;
  localparam int VT = 5;
  localparam int LF = 2;

  logic       clk_pix, rst_pix, hsync, vsync, de, r, g, b;
  logic [9:0] rx_x, rx_y, rx_frame;
  logic [2:0] rx_rgb;
  logic       rx_valid, locked, err_h, err_v;

  vga_timing_rx #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .SYNC_NEG(1), .LOCK_FRAMES(LF)
  ) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .hsync(hsync), .vsync(vsync), .de(de),
    .r(r), .g(g), .b(b), .rx_x(rx_x), .rx_y(rx_y), .rx_rgb(rx_rgb),
    .rx_valid(rx_valid), .rx_frame(rx_frame), .locked(locked),
    .err_h(err_h), .err_v(err_v)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] rgb;
    logic       valid;
    logic [9:0] frame;
    logic       lk;
    logic       eh;
    logic       ev;
  } exp_t;

  int   n_checks = 0;
  int   n_err = 0;
  int   n_eh = 0;
  int   n_ev = 0;
  int   fr_cnt = 0;
  bit   probe_en = 1'b0;
  bit   chk_zero = 1'b0;
  exp_t exp_cur = '0;
  exp_t exp_d1 = '0;

  // Model state, in terms of the driven stream.
  int m_run, m_lines, m_hper, m_mode, m_clean, m_frame;
  bit m_phs, m_pvs, m_pde, m_hseen, m_vseen, m_dirty;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_lines = 0; m_hper = 0; m_mode = 0; m_clean = 0; m_frame = 0;
    m_phs = 0; m_pvs = 0; m_pde = 0; m_hseen = 0; m_vseen = 0; m_dirty = 0;
    exp_cur = '0;
  endtask

  // mode: 0 searching, 1 acquiring, 2 locked
  task automatic model_step(input bit hsa, input bit vsa, input bit dei, input logic [2:0] c);
    bit hse, vse, rise, fall, eh, ev, err, unlock;
    int yv;
    hse = hsa && !m_phs;
    vse = vsa && !m_pvs;
    rise = dei && !m_pde;
    fall = !dei && m_pde;
    eh = 0; ev = 0; unlock = 0;
    if (fall && m_run != HA) eh = 1;
    if (rise) m_run = 1; else if (dei) m_run++;
    if (fall) m_lines++;
    yv = (m_lines > 1023) ? 1023 : m_lines;
    if (hse) begin
      if (m_hseen && m_hper != HT) eh = 1;
      m_hper = 1;
    end else if (m_hper < 1023) m_hper++;
    if (vse) begin
      if (m_vseen && yv != VA) ev = 1;
      m_lines = 0;
      m_vseen = 1;
      m_frame = (m_frame + 1) % 1024;
    end
    err = eh || ev;
    if (m_mode == 2) begin
      if (err) begin m_mode = 0; unlock = 1; end
    end else if (m_mode == 0) begin
      if (vse) begin m_mode = 1; m_clean = 0; end
    end else begin
      if (vse) begin
        if (err || m_dirty) m_clean = 0;
        else begin
          m_clean++;
          if (m_clean >= LF) m_mode = 2;
        end
      end else if (err) m_clean = 0;
    end
    if (vse) m_dirty = 0; else if (err) m_dirty = 1;
    if (unlock) m_hseen = 0; else if (hse) m_hseen = 1;
    exp_cur.valid = dei;
    exp_cur.rgb   = dei ? c : 3'b000;
    exp_cur.x     = dei ? 10'((m_run - 1 > 1023) ? 1023 : m_run - 1) : 10'd0;
    exp_cur.y     = 10'(yv);
    exp_cur.frame = 10'(m_frame);
    exp_cur.lk    = (m_mode == 2);
    exp_cur.eh    = eh;
    exp_cur.ev    = ev;
    m_phs = hsa; m_pvs = vsa; m_pde = dei;
  endtask

  // Drive one input cycle (active-level flags; syncs are negative on the pins).
  task automatic drive(input bit hsa, input bit vsa, input bit dei, input logic [2:0] c, input bit rst_i);
    @(negedge clk_pix);
    if (chk_zero) begin
      check("rst_rx_x", rx_x, 0);
      check("rst_rx_y", rx_y, 0);
      check("rst_rx_rgb", rx_rgb, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_frame", rx_frame, 0);
      check("rst_locked", locked, 0);
      check("rst_err_h", err_h, 0);
      check("rst_err_v", err_v, 0);
      chk_zero = 1'b0;
    end
    rst_pix = rst_i;
    hsync = ~hsa;
    vsync = ~vsa;
    de = dei;
    {r, g, b} = c;
    if (rst_i) begin
      model_reset();
      chk_zero = 1'b1;
    end else begin
      model_step(hsa, vsa, dei, c);
    end
  endtask

  // One frame: lines 0..VT-1, vsync from (VT-2, vs_sx) to (VT-1, vs_sx).
  task automatic frame(input int act, input int short_y, input int short_len,
                       input int vs_sx, input int rst_y, input int rst_sx);
    for (int sy = 0; sy < VT; sy++) begin
      int len;
      int tot;
      len = (sy == short_y) ? short_len : HA;
      tot = (len + 3 > HT) ? len + 3 : HT;
      for (int sx = 0; sx < tot; sx++) begin
        bit dei, hsa, vsa, rs;
        logic [2:0] c;
        dei = (sy < act) && (sx < len);
        hsa = (sx == tot - 2);
        vsa = ((sy == VT - 2) && (sx >= vs_sx)) || ((sy == VT - 1) && (sx < vs_sx));
        c = (sx == 5 && sy == 3) ? 3'b101 : 3'((sx + sy) % 8);
        rs = (sy == rst_y) && (sx == rst_sx);
        if (rs) fr_cnt = 0;
        drive(hsa, vsa, dei, c, rs);
        if (probe_en && sx == 5 && sy == 3) begin
          fork
            begin
              @(posedge clk_pix);
              @(posedge clk_pix);
              #2;
              check("probe_x", rx_x, 5);
              check("probe_y", rx_y, 3);
              check("probe_rgb", rx_rgb, 5);
              check("probe_valid", rx_valid, 1);
            end
          join_none
        end
      end
    end
    fr_cnt++;
  endtask

  task automatic nf();
    frame(VA, -1, HA, 7, -1, -1);
  endtask

  // Per-cycle comparison of DUT outputs against the model, one edge behind.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_pix);
      #1;
      if (rst_pix) e = '0; else e = exp_d1;
      exp_d1 = exp_cur;
      if (err_h) n_eh++;
      if (err_v) n_ev++;
      check("rx_valid", rx_valid, e.valid);
      check("rx_rgb", rx_rgb, e.rgb);
      check("rx_frame", rx_frame, e.frame);
      check("locked", locked, e.lk);
      check("err_h", err_h, e.eh);
      check("err_v", err_v, e.ev);
      if (e.valid) begin
        check("rx_x", rx_x, e.x);
        check("rx_y", rx_y, e.y);
      end
    end
  end

  initial begin
    int eh0, ev0;
    rst_pix = 1'b1; hsync = 1'b1; vsync = 1'b1; de = 1'b0; r = 1'b0; g = 1'b0; b = 1'b0;
    model_reset();
    repeat (4) drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);

    // Acquire lock from reset; lock at second clean vsync after the first.
    probe_en = 1'b1;
    nf();
    probe_en = 1'b0;
    nf();
    check("lock_after_2_frames", locked, 0);
    nf();
    check("lock_after_3_frames", locked, 1);
    check("frame_after_3", rx_frame, 3);
    check("no_err_h_acquire", n_eh, 0);
    check("no_err_v_acquire", n_ev, 0);

    // Short line while locked.
    eh0 = n_eh;
    frame(VA, 1, HA - 1, 7, -1, -1);
    check("short_line_err_h", n_eh - eh0, 1);
    check("short_line_unlock", locked, 0);
    nf(); nf();
    check("short_line_relock", locked, 1);

    // Missing active line.
    ev0 = n_ev;
    frame(VA - 1, -1, HA, 7, -1, -1);
    check("short_frame_err_v", n_ev - ev0, 1);
    check("short_frame_unlock", locked, 0);
    check("short_frame_count", rx_frame, fr_cnt % 1024);
    nf(); nf();
    check("short_frame_still_unlocked", locked, 0);
    nf();
    check("short_frame_relock", locked, 1);

    // de fall coincident with vsync assertion.
    eh0 = n_eh; ev0 = n_ev;
    frame(VA, -1, HA, HA, -1, -1);
    check("coincident_locked", locked, 1);
    check("coincident_no_err", (n_eh - eh0) + (n_ev - ev0), 0);

    // Overlong de saturates px; only the de-fall error fires.
    eh0 = n_eh;
    frame(VA, 1, 1100, 7, -1, -1);
    check("long_line_err_h", n_eh - eh0, 1);
    check("long_line_unlock", locked, 0);
    nf(); nf();
    check("long_line_relock", locked, 1);

    // One-cycle reset mid-frame during blanking.
    eh0 = n_eh; ev0 = n_ev;
    frame(VA, -1, HA, 7, 1, 8);
    check("post_reset_no_err", (n_eh - eh0) + (n_ev - ev0), 0);
    check("post_reset_frame", rx_frame, 1);
    check("post_reset_locked", locked, 0);
    nf();
    check("post_reset_acquiring", locked, 0);
    nf();
    check("post_reset_relock", locked, 1);

    // Frame counter wrap with lock held.
    while (fr_cnt < 1024) nf();
    check("wrap_frame_zero", rx_frame, 0);
    check("wrap_locked", locked, 1);
    nf();
    check("wrap_frame_one", rx_frame, 1);
    check("wrap_locked_after", locked, 1);

    repeat (3) @(negedge clk_pix);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_rx.md
VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_TOTAL, default 800, pixel clocks per line (hsync period).
REQ-003 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 SHALL have parameter SYNC_NEG, default 1; 1 = hsync/vsync asserted low.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, consecutive clean frames required to lock.
REQ-006 clk_pix  in  1  pixel clock; single clock domain.
REQ-007 rst_pix  in  1  reset, synchronous, active-high.
REQ-008 hsync, vsync, de  in  1 each  video timing inputs, same format the codebase's 640x480 driver emits.
REQ-009 r, g, b  in  1 each  pixel colour, qualified by de.
REQ-010 rx_x, rx_y  out  10 each  recovered coordinate of the pixel on rx_rgb.
REQ-011 rx_rgb  out  3  {r,g,b} of the recovered pixel.
REQ-012 rx_valid  out  1  rx_x/rx_y/rx_rgb hold an active pixel this cycle.
REQ-013 rx_frame  out  10  frame count, wraps 1023->0.
REQ-014 locked  out  1  timing matches parameters for LOCK_FRAMES frames.
REQ-015 err_h, err_v  out  1 each  one-cycle error pulses (line / frame timing).

Function
REQ-016 All inputs SHALL be registered once (stage 1); all outputs SHALL be registered (stage 2); input at edge k appears on outputs after edge k+1 (latency 2).
REQ-017 Sync assertion SHALL be the stage-1 transition inactive->active of hsync/vsync per SYNC_NEG.
REQ-018 Pixel counter px SHALL clear on de rising edge and increment each de-high cycle; rx_x = px for that pixel (first active pixel rx_x=0).
REQ-019 Line counter ln SHALL increment on each de falling edge and clear on vsync assertion; rx_y = ln during the line (first line after vsync rx_y=0).
REQ-020 rx_valid SHALL equal stage-1 de delayed one cycle; rx_rgb SHALL be 3'b000 when rx_valid=0.
REQ-021 Period counter hp (10 bit) SHALL count clocks between hsync assertions, clearing to 1 at each assertion, saturating at 1023.
REQ-022 err_h SHALL pulse on de falling edge when px+1 != H_ACTIVE, or on hsync assertion when hp != H_TOTAL (first hsync after reset/unlock exempt).
REQ-023 err_v SHALL pulse on vsync assertion when ln != V_ACTIVE (first vsync after reset exempt).
REQ-024 rx_frame SHALL increment on every vsync assertion regardless of lock state.
REQ-025 Lock FSM states SEARCH, ACQUIRE, LOCKED; SEARCH->ACQUIRE on first vsync assertion; clean-frame counter cleared on entering ACQUIRE.
REQ-026 ACQUIRE: each vsync assertion with no err_h/err_v since previous vsync increments clean count; reaching LOCK_FRAMES -> LOCKED; any error -> clean count 0, stay ACQUIRE.
REQ-027 LOCKED: any err_h or err_v -> SEARCH in the same cycle the pulse is registered; locked=1 only in LOCKED.
REQ-028 de high for more than 1023 cycles SHALL saturate px at 1023 and raise err_h at de fall; ln SHALL saturate at 1023.
REQ-029 Simultaneous de fall and vsync assertion: ln increment first, then V check uses incremented value, then clear.
REQ-030 Simultaneous hsync and vsync assertion SHALL be legal; both checks evaluated.

Reset
REQ-031 While rst_pix=1 (sampled at clk_pix): rx_x=0, rx_y=0, rx_rgb=0, rx_valid=0, rx_frame=0, locked=0, err_h=0, err_v=0, FSM=SEARCH, all counters and stage-1 regs cleared to inactive sync levels.
REQ-032 Reset asserted mid-line or mid-frame SHALL abort immediately; first sync edges after release are exempt from checks.

Verification
REQ-033 Drive the codebase 640x480 driver output (800x525, negative syncs) -> locked rises at 2nd clean vsync after first vsync; no err pulses; rx_x 0..639, rx_y 0..479.
REQ-034 Pixel at sx=5, sy=3 with rgb=3'b101 -> rx_x=5, rx_y=3, rx_rgb=3'b101, rx_valid=1 exactly 2 cycles after input edge.
REQ-035 While locked, shorten one line's de to 639 cycles -> single err_h pulse at de fall, locked drops same cycle, relocks after 2 clean frames.
REQ-036 Frame with 479 active lines -> err_v pulse at vsync assertion, locked=0; rx_frame still increments.
REQ-037 Assert rst_pix for 1 cycle mid-frame -> all outputs zero next cycle; no err pulse on first post-reset hsync/vsync.
REQ-038 Run 1024 frames -> rx_frame wraps 1023->0 with locked held at 1.
